// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO family: read-mode constants,
// default threshold levels and a constant-foldable ceil(log2) helper.
package fifo_pkg;

  localparam int FWFT_MODE  = 1;
  localparam int REG_MODE   = 0;
  localparam int DEF_AE_LVL = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Write/read/status bundle of sync_fifo_param. The master drives the requests,
// the slave (the FIFO) drives data and status back.
interface sync_fifo_param_if #(
  parameter int W  = 77,
  parameter int AW = 4
);
  // wr_en/rd_en are requests, not handshakes: a write lands only when wr_full
  // was low on that edge, a read pops only when rd_empty was low.
  logic          flush;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          wr_full;
  logic          wr_afull;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          rd_empty;
  logic          rd_aempty;
  logic [AW:0]   count;
  logic          ovf;
  logic          udf;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  wr_full, wr_afull, rd_data, rd_empty, rd_aempty, count, ovf, udf
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output wr_full, wr_afull, rd_data, rd_empty, rd_aempty, count, ovf, udf
  );
endinterface

// File: rtl/fifo_ram_dp.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous
// read port, no reset so it maps onto distributed RAM or a register file.
module fifo_ram_dp
  import fifo_pkg::*;
#(
  parameter  int W  = 77,
  parameter  int DP = 16,
  localparam int AW = clog2(DP)
)(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DP];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with programmable almost-full/empty levels, occupancy count,
// synchronous flush, sticky overflow/underflow and show-ahead or registered read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int W      = 77,
  parameter int DP     = 16,
  parameter int FWFT   = FWFT_MODE,
  parameter int AF_LVL = DP - 1,
  parameter int AE_LVL = DEF_AE_LVL
)(
  input  logic             clk,
  input  logic             reset,
  sync_fifo_param_if.slave bus
);

  localparam int          AW   = clog2(DP);
  localparam logic [AW:0] DP_C = DP[AW:0];
  localparam logic [AW:0] AF_C = AF_LVL[AW:0];
  localparam logic [AW:0] AE_C = AE_LVL[AW:0];

  logic [AW:0]  wr_ptr, rd_ptr, cnt_q;
  logic [AW:0]  wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
  logic         wr_ok, rd_ok;
  logic         full_q, afull_q, empty_q, aempty_q, ovf_q, udf_q;
  logic [W-1:0] ram_rd;

  // Acceptance looks only at registered flags, so a full FIFO never passes a
  // same-cycle write through a read, and flush overrides both requests.
  always_comb begin
    wr_ok      = bus.wr_en & ~full_q & ~bus.flush;
    rd_ok      = bus.rd_en & ~empty_q & ~bus.flush;
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, wr_ok};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, rd_ok};
    if (bus.flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end
    cnt_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      cnt_q    <= cnt_nxt;
      full_q   <= (cnt_nxt == DP_C);
      afull_q  <= (cnt_nxt >= AF_C);
      empty_q  <= (cnt_nxt == '0);
      aempty_q <= (cnt_nxt <= AE_C);
      ovf_q    <= ~bus.flush & (ovf_q | (bus.wr_en & full_q));
      udf_q    <= ~bus.flush & (udf_q | (bus.rd_en & empty_q));
    end
  end

  fifo_ram_dp #(.W(W), .DP(DP)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rd)
  );

  generate
    if (FWFT != 0) begin : g_show_ahead
      assign bus.rd_data = ram_rd;
    end else begin : g_registered
      logic [W-1:0] rd_data_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)      rd_data_q <= '0;
        else if (rd_ok) rd_data_q <= ram_rd;
      end
      assign bus.rd_data = rd_data_q;
    end
  endgenerate

  assign bus.wr_full   = full_q;
  assign bus.wr_afull  = afull_q;
  assign bus.rd_empty  = empty_q;
  assign bus.rd_aempty = aempty_q;
  assign bus.count     = cnt_q;
  assign bus.ovf       = ovf_q;
  assign bus.udf       = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a show-ahead and a registered-read instance get the
// same stimulus and are compared against one queue-based reference model.
module tb_sync_fifo_param;

  localparam int W    = 77;
  localparam int DP   = 16;
  localparam int AW   = 4;
  localparam int AF_A = 15;
  localparam int AE_A = 1;
  localparam int AF_B = 12;
  localparam int AE_B = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.W(W), .AW(AW)) if_a ();
  sync_fifo_param_if #(.W(W), .AW(AW)) if_b ();

  sync_fifo_param #(.W(W), .DP(DP), .FWFT(1), .AF_LVL(AF_A), .AE_LVL(AE_A)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );

  sync_fifo_param #(.W(W), .DP(DP), .FWFT(0), .AF_LVL(AF_B), .AE_LVL(AE_B)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         m_ovf;
  logic         m_udf;
  logic [W-1:0] m_rd_b;
  int           wr_acc;
  int           n_checks;
  int           n_errors;

  task automatic model_reset();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_rd_b = '0;
  endtask

  task automatic model_step(input bit fl, input bit wr, input logic [W-1:0] wd, input bit rd);
    int n;
    n = exp_q.size();
    if (fl) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr && n == DP) m_ovf = 1'b1;
      if (rd && n == 0)  m_udf = 1'b1;
      if (rd && n > 0)   m_rd_b = exp_q.pop_front();
      if (wr && n < DP) begin
        exp_q.push_back(wd);
        wr_acc++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, " a.count"},  W'(if_a.count),     W'(n));
    chk({tag, " a.empty"},  W'(if_a.rd_empty),  W'(n == 0));
    chk({tag, " a.full"},   W'(if_a.wr_full),   W'(n == DP));
    chk({tag, " a.afull"},  W'(if_a.wr_afull),  W'(n >= AF_A));
    chk({tag, " a.aempty"}, W'(if_a.rd_aempty), W'(n <= AE_A));
    chk({tag, " a.ovf"},    W'(if_a.ovf),       W'(m_ovf));
    chk({tag, " a.udf"},    W'(if_a.udf),       W'(m_udf));
    if (n > 0) chk({tag, " a.rd_data"}, if_a.rd_data, exp_q[0]);
    chk({tag, " b.count"},  W'(if_b.count),     W'(n));
    chk({tag, " b.empty"},  W'(if_b.rd_empty),  W'(n == 0));
    chk({tag, " b.full"},   W'(if_b.wr_full),   W'(n == DP));
    chk({tag, " b.afull"},  W'(if_b.wr_afull),  W'(n >= AF_B));
    chk({tag, " b.aempty"}, W'(if_b.rd_aempty), W'(n <= AE_B));
    chk({tag, " b.ovf"},    W'(if_b.ovf),       W'(m_ovf));
    chk({tag, " b.udf"},    W'(if_b.udf),       W'(m_udf));
    chk({tag, " b.rd_data"}, if_b.rd_data, m_rd_b);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit fl, input bit wr, input logic [W-1:0] wd, input bit rd);
    if_a.flush = fl; if_a.wr_en = wr; if_a.wr_data = wd; if_a.rd_en = rd;
    if_b.flush = fl; if_b.wr_en = wr; if_b.wr_data = wd; if_b.rd_en = rd;
  endtask

  // Inputs change 1ns after an edge; outputs are sampled 1ns after the next edge.
  task automatic cycle(input string tag, input bit fl, input bit wr, input logic [W-1:0] wd, input bit rd);
    set_in(fl, wr, wd, rd);
    @(posedge clk);
    model_step(fl, wr, wd, rd);
    #1;
    check_all(tag);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit fl;
    bit wr;
    bit rd;
    int e_cnt;
    bit e_empty;
    bit e_ovf;
    bit e_udf;
  } vec_t;

  vec_t vt[9];

  initial begin
    bit fl, wr, rd;

    n_checks = 0;
    n_errors = 0;
    wr_acc   = 0;
    model_reset();
    set_in(1'b0, 1'b0, '0, 1'b0);
    reset = 1'b1;

    // From empty: underflow, empty+write, simple traffic, flush over requests.
    vt[0] = '{fl:0, wr:0, rd:1, e_cnt:0, e_empty:1, e_ovf:0, e_udf:1};
    vt[1] = '{fl:0, wr:1, rd:1, e_cnt:1, e_empty:0, e_ovf:0, e_udf:1};
    vt[2] = '{fl:0, wr:1, rd:0, e_cnt:2, e_empty:0, e_ovf:0, e_udf:1};
    vt[3] = '{fl:0, wr:0, rd:1, e_cnt:1, e_empty:0, e_ovf:0, e_udf:1};
    vt[4] = '{fl:0, wr:1, rd:1, e_cnt:1, e_empty:0, e_ovf:0, e_udf:1};
    vt[5] = '{fl:1, wr:1, rd:1, e_cnt:0, e_empty:1, e_ovf:0, e_udf:0};
    vt[6] = '{fl:0, wr:0, rd:0, e_cnt:0, e_empty:1, e_ovf:0, e_udf:0};
    vt[7] = '{fl:0, wr:1, rd:0, e_cnt:1, e_empty:0, e_ovf:0, e_udf:0};
    vt[8] = '{fl:0, wr:0, rd:1, e_cnt:0, e_empty:1, e_ovf:0, e_udf:0};

    #1;
    check_all("reset");
    #11;
    reset = 1'b0;
    cycle("idle", 1'b0, 1'b0, '0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      cycle($sformatf("vec%0d", i), vt[i].fl, vt[i].wr, W'(32'h1000 + i), vt[i].rd);
      chk($sformatf("vec%0d count", i), W'(if_a.count),    W'(vt[i].e_cnt));
      chk($sformatf("vec%0d empty", i), W'(if_a.rd_empty), W'(vt[i].e_empty));
      chk($sformatf("vec%0d ovf", i),   W'(if_b.ovf),      W'(vt[i].e_ovf));
      chk($sformatf("vec%0d udf", i),   W'(if_b.udf),      W'(vt[i].e_udf));
    end

    // Fill 0..15, watch the upper thresholds, then drain in order.
    for (int i = 0; i < DP; i++) begin
      cycle("fill", 1'b0, 1'b1, W'(i), 1'b0);
      chk("fill afull", W'(if_a.wr_afull), W'(i + 1 >= 15));
      chk("fill full",  W'(if_a.wr_full),  W'(i + 1 == 16));
    end
    for (int i = 0; i < DP; i++) begin
      chk("drain order", if_a.rd_data, W'(i));
      cycle("drain", 1'b0, 1'b0, '0, 1'b1);
    end
    chk("drain empty", W'(if_a.rd_empty), W'(1));

    // Full with write+read: read wins, write dropped, overflow latched.
    for (int i = 0; i < DP; i++) cycle("refill", 1'b0, 1'b1, W'(100 + i), 1'b0);
    cycle("full_wr_rd", 1'b0, 1'b1, W'(32'hDEAD), 1'b1);
    chk("full_wr_rd count", W'(if_a.count), W'(15));
    chk("full_wr_rd ovf",   W'(if_a.ovf),   W'(1));
    for (int i = 1; i < DP; i++) begin
      chk("post_ovf order", if_a.rd_data, W'(100 + i));
      cycle("post_ovf drain", 1'b0, 1'b0, '0, 1'b1);
    end

    // Registered read path: data appears on the read edge, not before.
    cycle("b_write", 1'b0, 1'b1, W'(55), 1'b0);
    chk("b_before_read", if_b.rd_data, W'(115));
    cycle("b_read", 1'b0, 1'b0, '0, 1'b1);
    chk("b_after_read", if_b.rd_data, W'(55));

    // Flush at count 9 with both error flags set.
    cycle("udf_set", 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 9; i++) cycle("to9", 1'b0, 1'b1, W'(200 + i), 1'b0);
    chk("count9", W'(if_a.count), W'(9));
    cycle("flush9", 1'b1, 1'b1, W'(7), 1'b1);
    chk("flush count", W'(if_b.count), W'(0));
    chk("flush ovf",   W'(if_b.ovf),   W'(0));
    chk("flush udf",   W'(if_a.udf),   W'(0));
    chk("flush hold",  if_b.rd_data,   W'(55));

    // Random interleaving across many pointer wraps.
    wr_acc = 0;
    for (int c = 0; c < 1000; c++) begin
      fl = ($urandom_range(0, 63) == 0);
      wr = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 50);
      cycle("rand", fl, wr, rand_word(), rd);
    end
    chk("rand wraps", W'(wr_acc >= 3 * 2 * DP), W'(1));

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b0, 1'b1, rand_word(), 1'b0);
    set_in(1'b0, 1'b0, '0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    reset = 1'b0;
    cycle("post_rst", 1'b0, 1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
